// File: rtl/top_level_sys_if.sv
// Board I/O bundle for the Project2 display counter: push button in,
// three seven-segment digits and the run LED out.
interface top_level_sys_if;
  logic       toggleBtn;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       LEDG;

  modport master (
    output toggleBtn,
    input  HEX0, HEX1, HEX2, LEDG
  );

  modport slave (
    input  toggleBtn,
    output HEX0, HEX1, HEX2, LEDG
  );
endinterface

// File: rtl/top_level_sys.sv
// Project2 display counter: prescaled 000..999 BCD counter on active-low 7-seg
// displays, run/pause push button. Define TOP_LEVEL_DEBOUNCE_EN for debounce.
module top_level_sys #(
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  top_level_sys_if.slave io
);

  localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} run_state_e;

  run_state_e    run_q, run_d;
  logic          sync1_q, sync2_q, level_prev_q;
  logic          btn_level, press, tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_prev_q <= 1'b1;
    end else begin
      sync1_q      <= io.toggleBtn;
      sync2_q      <= sync1_q;
      level_prev_q <= btn_level;
    end
  end

`ifdef TOP_LEVEL_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_q, db_d;

  // Any cycle where the input agrees with the debounced level restarts the run.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else                                      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_level = db_q;
`else
  assign btn_level = sync2_q;
`endif

  assign press = level_prev_q & ~btn_level;
  assign tick  = (run_q == RUNNING) && (presc_q == PRESC_LAST);

  // Run/pause state machine; the tick above uses the pre-toggle state.
  always_comb begin
    run_d = run_q;
    if (press) run_d = (run_q == RUNNING) ? PAUSED : RUNNING;
  end

  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    if (run_q == RUNNING) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        if (tens_q == 4'd9) begin
          tens_d = '0;
          hund_d = (hund_q == 4'd9) ? '0 : hund_q + 4'd1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= RUNNING;
      presc_q <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else begin
      run_q   <= run_d;
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign io.HEX0 = seg7(ones_q);
  assign io.HEX1 = seg7(tens_q);
  assign io.HEX2 = seg7(hund_q);
  assign io.LEDG = (run_q == RUNNING);

endmodule

// File: tb/tb_top_level_sys.sv
// Bench for top_level_sys (default build): behavioural counter model checked
// every cycle, plus directed literal checks for reset, wrap, pause and reset.
module tb_top_level_sys;

  localparam int TD = 3;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  top_level_sys_if io ();

  top_level_sys #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(8)) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: decimal count with a prescaler; a press is a 1->0 step in the
  // sampled button seen three edges late.
  int       m_count, m_presc, mc, mp;
  bit       m_run;
  bit [2:0] m_hist;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_presc <= 0;
      m_run   <= 1'b1;
      m_hist  <= 3'b111;
    end else begin
      mc = m_count;
      mp = m_presc;
      if (m_run) begin
        if (mp == TD - 1) begin
          mp = 0;
          mc = (mc + 1) % 1000;
        end else begin
          mp = mp + 1;
        end
      end
      m_count <= mc;
      m_presc <= mp;
      if (m_hist[2] && !m_hist[1]) m_run <= !m_run;
      m_hist <= {m_hist[1:0], io.toggleBtn};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_HEX0", {25'b0, io.HEX0}, {25'b0, SEG[m_count % 10]});
      check("model_HEX1", {25'b0, io.HEX1}, {25'b0, SEG[(m_count / 10) % 10]});
      check("model_HEX2", {25'b0, io.HEX2}, {25'b0, SEG[m_count / 100]});
      check("model_LEDG", {31'b0, io.LEDG}, {31'b0, m_run});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_btn(input logic v);
    @(negedge clk);
    io.toggleBtn = v;
  endtask

  int   trans;
  logic prev_led;

  initial begin
    io.toggleBtn = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_HEX0", {25'b0, io.HEX0}, 32'b1000000);
    check("rst_HEX1", {25'b0, io.HEX1}, 32'b1000000);
    check("rst_HEX2", {25'b0, io.HEX2}, 32'b1000000);
    check("rst_LEDG", {31'b0, io.LEDG}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // First increment lands exactly TD edges after release.
    edges(TD - 1);
    check("pre_first_inc", {25'b0, io.HEX0}, 32'b1000000);
    edges(1);
    check("first_inc", {25'b0, io.HEX0}, 32'b1111001);

    // Carry chain and 999 -> 000 wrap.
    do_reset();
    edges(999 * TD);
    check("c999_HEX0", {25'b0, io.HEX0}, 32'b0010000);
    check("c999_HEX1", {25'b0, io.HEX1}, 32'b0010000);
    check("c999_HEX2", {25'b0, io.HEX2}, 32'b0010000);
    edges(TD);
    check("wrap_HEX0", {25'b0, io.HEX0}, 32'b1000000);
    check("wrap_HEX2", {25'b0, io.HEX2}, 32'b1000000);

    // Pause at 005 with the prescaler left at 1, then resume.
    do_reset();
    edges(5 * TD - 2);
    set_btn(1'b0);
    edges(2);
    check("pause_lat2_LEDG", {31'b0, io.LEDG}, 32'd1);
    check("pause_cnt5", {25'b0, io.HEX0}, 32'b0010010);
    edges(1);
    check("pause_lat3_LEDG", {31'b0, io.LEDG}, 32'd0);
    edges(100);
    check("frozen_HEX0", {25'b0, io.HEX0}, 32'b0010010);
    check("frozen_HEX1", {25'b0, io.HEX1}, 32'b1000000);
    check("frozen_LEDG", {31'b0, io.LEDG}, 32'd0);
    set_btn(1'b1);
    edges(10);
    check("release_noop", {31'b0, io.LEDG}, 32'd0);
    set_btn(1'b0);
    edges(3);
    check("resume_LEDG", {31'b0, io.LEDG}, 32'd1);
    edges(1);
    check("resume_hold5", {25'b0, io.HEX0}, 32'b0010010);
    edges(1);
    check("resume_inc6", {25'b0, io.HEX0}, 32'b0000010);
    set_btn(1'b1);
    edges(10);

    // Held button: exactly one run->pause transition.
    prev_led = io.LEDG;
    trans = 0;
    set_btn(1'b0);
    for (int i = 0; i < 10000; i++) begin
      edges(1);
      if (io.LEDG !== prev_led) trans++;
      prev_led = io.LEDG;
    end
    check("held_transitions", trans, 32'd1);
    check("held_LEDG", {31'b0, io.LEDG}, 32'd0);
    set_btn(1'b1);
    edges(10);
    check("held_release_LEDG", {31'b0, io.LEDG}, 32'd0);

    // Tick and toggle on the same edge, then async reset mid-cycle at 037.
    do_reset();
    edges(37 * TD - 3);
    set_btn(1'b0);
    edges(3);
    check("sim_HEX1", {25'b0, io.HEX1}, 32'b0110000);
    check("sim_HEX0", {25'b0, io.HEX0}, 32'b1111000);
    check("sim_LEDG", {31'b0, io.LEDG}, 32'd0);
    set_btn(1'b1);
    edges(5);
    check("c37_hold", {25'b0, io.HEX0}, 32'b1111000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_HEX0", {25'b0, io.HEX0}, 32'b1000000);
    check("arst_HEX1", {25'b0, io.HEX1}, 32'b1000000);
    check("arst_HEX2", {25'b0, io.HEX2}, 32'b1000000);
    check("arst_LEDG", {31'b0, io.LEDG}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    edges(TD);
    check("arst_restart", {25'b0, io.HEX0}, 32'b1111001);

    edges(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/top_level_sys.md
Name: top_level_sys

Overview:
- Board-level top for the Project2 display counter.
- A 50 MHz clock drives a prescaler that advances a 3-digit decimal (BCD) counter, 000..999, wrapping.
- The counter is shown on three active-low seven-segment displays.
- An active-low push button toggles counting between run and pause; LEDG shows the run state.

Parameters:
- TICK_DIV, 5000000, clock cycles per count increment (10 Hz at 50 MHz); legal range >= 2.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before the debounced button changes (used only with DEBOUNCE_EN).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- toggleBtn  input  1  push button, active-low (0 = pressed), asynchronous to CLOCK_50.
- HEX0  output  7  ones digit, active-low segments; bit0=a .. bit6=g.
- HEX1  output  7  tens digit, same encoding.
- HEX2  output  7  hundreds digit, same encoding.
- LEDG  output  1  1 = running, 0 = paused.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - counter = 000, prescaler = 0, running = 1, synchronizer/debounce flops = 1 (released).
  - Outputs during and right after reset: HEX2/1/0 all show 0 (7'b1000000), LEDG = 1.
- Button path:
  - 2-flop synchronizer on toggleBtn, then a falling-edge detector on the synchronized (or debounced) level.
  - A detected press flips running.
  - Holding the button gives exactly one toggle; release does nothing.
  - Without debounce, running flips on the 3rd rising clock edge after toggleBtn falls, assuming setup is met.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while running.
  - Holds its value while paused; it is not cleared.
  - At TICK_DIV-1 with running=1: prescaler -> 0 and counter increments on the same edge.
  - First increment occurs TICK_DIV clock edges after reset release.
- Counter: three BCD digits.
  - Ones digit 9 -> 0 with carry into tens; tens 9 -> 0 with carry into hundreds.
  - 999 -> 000, no flag.
- Simultaneous increment tick and button press on the same edge: the increment is applied, then running flips (the tick uses the pre-toggle running value).
- Segment decode is combinational from the registered digits. Active-low codes for bits g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Unreachable BCD values 10..15 decode to blank (1111111).
- LEDG = running, registered.
- Reset mid-count: all state returns to reset values immediately; counting restarts from 000 after release with running = 1.

Optional Feature:
- Macro: TOP_LEVEL_DEBOUNCE_EN.
- Defined:
  - A counter follows the synchronized button.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - The edge detector uses the debounced level.
  - Toggle latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Not defined: the edge detector uses the synchronizer output directly; no debounce counter is instantiated.

Test Plan:
- Reset/idle: pulse reset_n low 10 ns with TICK_DIV=10, toggleBtn=1 -> HEX2/1/0=1000000, LEDG=1; after 10 cycles HEX0=1111001 (count 001).
- Carry/wrap: run TICK_DIV=2 for 2*999 cycles -> HEX2/1/0 show 9/9/9 (0010000 each); 2 more cycles -> 000.
- Pause/resume: press toggleBtn (1 -> 0, held 100 cycles) at count 005 -> LEDG=0 within 3 cycles, count frozen at 005. Release, press again -> LEDG=1, next increment after the remaining prescaler cycles (held prescaler value preserved).
- Held button: toggleBtn=0 for 100000 ns -> exactly one LEDG transition (1 -> 0).
- Async reset mid-count: assert reset_n=0 between clock edges at count 037 -> outputs read 000 and LEDG=1 before the next clock edge.
- Debounce (TOP_LEVEL_DEBOUNCE_EN, DEBOUNCE_CYCLES=8): glitch toggleBtn low for 5 cycles -> no toggle; low for 20 cycles -> one toggle, 11 cycles after the falling edge.
